// File: rtl/picocode_bank_ctrl_if.sv
// Fetch, ROM, remap and upload signals of the picocode bank controller.
// master = CPU/host/ROM side, slave = controller.
interface picocode_bank_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 18,
  parameter int BW = 3
);
  logic [AW-1:0] inst_address;
  logic [DW-1:0] inst_data_out;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data;
  logic [BW-1:0] active_bank;
  logic          remap_req;
  logic [BW-1:0] remap_bank;
  logic          remap_ack;
  logic          load_start;
  logic [BW-1:0] load_bank;
  logic [AW-1:0] load_base;
  logic          load_valid;
  logic          load_ready;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;
  logic [DW-1:0] load_sum;

  modport master (
    output inst_address, rom_data, remap_req, remap_bank, load_start, load_bank,
           load_base, load_valid, load_data, load_last,
    input  inst_data_out, rom_address, active_bank, remap_ack, load_ready,
           load_busy, load_done, load_err, load_count, load_sum
  );

  modport slave (
    input  inst_address, rom_data, remap_req, remap_bank, load_start, load_bank,
           load_base, load_valid, load_data, load_last,
    output inst_data_out, rom_address, active_bank, remap_ack, load_ready,
           load_busy, load_done, load_err, load_count, load_sum
  );
endinterface

// File: rtl/picocode_bank_ctrl.sv
// Picocode store: fetches from external ROM or one of NBANK RAM banks with 1-cycle latency.
// Uploads fill a non-active bank; load_ready is held high for the whole LOAD state.
module picocode_bank_ctrl #(
  parameter int AW         = 10,
  parameter int DW         = 18,
  parameter int NBANK      = 2,
  parameter int RESET_BANK = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  picocode_bank_ctrl_if.slave bus
);
  localparam int BW = 3;
  localparam int IW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [BW-1:0] NBANK_B = BW'(NBANK);
  localparam logic [BW-1:0] RESET_B = BW'(RESET_BANK);
  localparam logic [AW:0]   FULL_M1 = {1'b0, {AW{1'b1}}};

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state;
  logic [BW-1:0] active_bank;
  logic [BW-1:0] ld_bank;
  logic [BW-1:0] pend_bank;
  logic [BW-1:0] fetch_bank;
  logic          pend_vld;
  logic          fetch_vld;
  logic [AW-1:0] ld_addr;
  logic [AW:0]   load_count;
  logic [DW-1:0] load_sum;
  logic [DW-1:0] ram_q;
  logic          remap_ack;
  logic          load_done;
  logic          load_err;

  logic [DW-1:0] mem [NBANK][2**AW];

  logic          remap_ok;
  logic          remap_bad;
  logic          remap_to_ld;
  logic          beat;
  logic          beat_end;
  logic          start_ok;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  assign remap_ok    = bus.remap_req && (bus.remap_bank <= NBANK_B);
  assign remap_bad   = bus.remap_req && !remap_ok;
  assign remap_to_ld = remap_ok && (bus.remap_bank == ld_bank);
  assign beat        = (state == LOAD) && bus.load_valid;
  assign beat_end    = beat && (bus.load_last || (load_count == FULL_M1));

  // A remap to the same bank in the same cycle takes precedence over the upload.
  assign start_ok = (state == IDLE) && bus.load_start
                 && (bus.load_bank != '0) && (bus.load_bank <= NBANK_B)
                 && (bus.load_bank != active_bank)
                 && !(remap_ok && (bus.remap_bank == bus.load_bank))
                 && !(pend_vld && (pend_bank == bus.load_bank));

  assign rd_idx = IW'(active_bank - 1'b1);
  assign wr_idx = IW'(ld_bank - 1'b1);

  // Bank storage survives reset; the loading bank is never the one being read.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_idx][ld_addr] <= bus.load_data;
    end
    ram_q <= mem[rd_idx][bus.inst_address];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_vld  <= 1'b0;
      fetch_bank <= RESET_B;
    end else begin
      fetch_vld  <= 1'b1;
      fetch_bank <= active_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      active_bank <= RESET_B;
      ld_bank     <= '0;
      ld_addr     <= '0;
      pend_vld    <= 1'b0;
      pend_bank   <= '0;
      load_count  <= '0;
      load_sum    <= '0;
      remap_ack   <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      remap_ack <= 1'b0;
      load_done <= 1'b0;
      load_err  <= remap_bad || (bus.load_start && !start_ok);
      case (state)
        IDLE: begin
          if (remap_ok) begin
            active_bank <= bus.remap_bank;
            remap_ack   <= 1'b1;
          end
          if (start_ok) begin
            state      <= LOAD;
            ld_bank    <= bus.load_bank;
            ld_addr    <= bus.load_base;
            load_count <= '0;
            load_sum   <= '0;
          end
        end
        LOAD: begin
          // Any newer remap supersedes the parked one.
          if (remap_to_ld) begin
            pend_vld  <= 1'b1;
            pend_bank <= bus.remap_bank;
          end else if (remap_ok) begin
            active_bank <= bus.remap_bank;
            remap_ack   <= 1'b1;
            pend_vld    <= 1'b0;
          end
          if (beat) begin
            ld_addr    <= ld_addr + 1'b1;
            load_count <= load_count + 1'b1;
            load_sum   <= load_sum + bus.load_data;
          end
          if (beat_end) begin
            state     <= IDLE;
            load_done <= 1'b1;
            if (remap_to_ld) begin
              active_bank <= bus.remap_bank;
              remap_ack   <= 1'b1;
              pend_vld    <= 1'b0;
            end else if (pend_vld && !remap_ok) begin
              active_bank <= pend_bank;
              remap_ack   <= 1'b1;
              pend_vld    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_address   = bus.inst_address;
  assign bus.inst_data_out = !fetch_vld ? '0 : ((fetch_bank == '0) ? bus.rom_data : ram_q);
  assign bus.active_bank   = active_bank;
  assign bus.remap_ack     = remap_ack;
  assign bus.load_ready    = (state == LOAD);
  assign bus.load_busy     = (state == LOAD);
  assign bus.load_done     = load_done;
  assign bus.load_err      = load_err;
  assign bus.load_count    = load_count;
  assign bus.load_sum      = load_sum;
endmodule

// File: tb/tb_picocode_bank_ctrl.sv
// Bench for picocode_bank_ctrl: directed vector table, hand sequences, then random traffic
// checked against a transaction-level model of banks, uploads and remaps.
module tb_picocode_bank_ctrl;
  localparam int AW = 10;
  localparam int DW = 18;
  localparam int NBANK = 2;
  localparam int RESET_BANK = 0;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  picocode_bank_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  picocode_bank_ctrl #(.AW(AW), .DW(DW), .NBANK(NBANK), .RESET_BANK(RESET_BANK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {a, 8'hA5};
  endfunction

  // External synchronous ROM
  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_address);

  typedef struct packed {
    logic [AW-1:0] inst_address;
    logic          remap_req;
    logic [2:0]    remap_bank;
    logic          load_start;
    logic [2:0]    load_bank;
    logic [AW-1:0] load_base;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
  } in_t;

  typedef struct {
    in_t           i;
    logic [2:0]    act;
    logic          ack, done, err, busy;
    int            cnt;
    int            sum;
    bit            ci;
    logic [DW-1:0] inst;
  } vec_t;

  int checks = 0;
  int errors = 0;
  in_t cur;

  // Reference model state
  logic [2:0]    m_active, m_ld_bank, m_pend_bank;
  bit            m_loading, m_pend;
  logic [AW-1:0] m_ld_addr;
  int            m_count;
  logic [DW-1:0] m_sum;
  bit            e_ack, e_done, e_err, e_known;
  logic [DW-1:0] e_inst;
  logic [DW-1:0] m_mem [int];

  function automatic in_t mkin(int ia, int rr, int rb, int ls, int lb, int base,
                               int lv, int ld, int ll);
    in_t r;
    r.inst_address = AW'(ia);
    r.remap_req    = rr[0];
    r.remap_bank   = 3'(rb);
    r.load_start   = ls[0];
    r.load_bank    = 3'(lb);
    r.load_base    = AW'(base);
    r.load_valid   = lv[0];
    r.load_data    = DW'(ld);
    r.load_last    = ll[0];
    return r;
  endfunction

  function automatic vec_t mkv(in_t i, int act, int ack, int done, int err, int busy,
                               int cnt, int sum, int ci, logic [DW-1:0] inst);
    vec_t v;
    v.i = i; v.act = 3'(act); v.ack = ack[0]; v.done = done[0]; v.err = err[0];
    v.busy = busy[0]; v.cnt = cnt; v.sum = sum; v.ci = ci[0]; v.inst = inst;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    cur                  = i;
    bus.inst_address     = i.inst_address;
    bus.remap_req        = i.remap_req;
    bus.remap_bank       = i.remap_bank;
    bus.load_start       = i.load_start;
    bus.load_bank        = i.load_bank;
    bus.load_base        = i.load_base;
    bus.load_valid       = i.load_valid;
    bus.load_data        = i.load_data;
    bus.load_last        = i.load_last;
  endtask

  task automatic model_reset();
    m_active = 3'(RESET_BANK); m_loading = 0; m_pend = 0; m_count = 0; m_sum = '0;
    e_ack = 0; e_done = 0; e_err = 0; e_inst = '0; e_known = 1;
  endtask

  // Effect of one clock edge given the inputs held during the preceding cycle.
  task automatic model_edge();
    logic [2:0] old_active;
    bit rv;
    int k;
    old_active = m_active;
    e_ack = 0; e_done = 0; e_err = 0;
    k = int'(m_active) * DEPTH + int'(cur.inst_address);
    if (m_active == 0) begin
      e_inst = rom_fn(cur.inst_address); e_known = 1;
    end else if (m_mem.exists(k)) begin
      e_inst = m_mem[k]; e_known = 1;
    end else begin
      e_known = 0;
    end
    rv = cur.remap_req && (int'(cur.remap_bank) <= NBANK);
    if (cur.remap_req && !rv) e_err = 1;
    if (!m_loading) begin
      if (rv) begin m_active = cur.remap_bank; e_ack = 1; end
      if (cur.load_start) begin
        if (cur.load_bank >= 1 && int'(cur.load_bank) <= NBANK && cur.load_bank != old_active
            && !(rv && cur.remap_bank == cur.load_bank)) begin
          m_loading = 1; m_ld_bank = cur.load_bank; m_ld_addr = cur.load_base;
          m_count = 0; m_sum = '0;
        end else begin
          e_err = 1;
        end
      end
    end else begin
      if (cur.load_start) e_err = 1;
      if (rv && cur.remap_bank == m_ld_bank) begin
        m_pend = 1; m_pend_bank = cur.remap_bank;
      end else if (rv) begin
        m_active = cur.remap_bank; e_ack = 1; m_pend = 0;
      end
      if (cur.load_valid) begin
        m_mem[int'(m_ld_bank) * DEPTH + int'(m_ld_addr)] = cur.load_data;
        m_ld_addr = m_ld_addr + 1'b1;
        m_count++;
        m_sum = m_sum + cur.load_data;
        if (cur.load_last || m_count == DEPTH) begin
          m_loading = 0; e_done = 1;
          if (m_pend) begin m_active = m_pend_bank; e_ack = 1; m_pend = 0; end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmp_model(input int n);
    chk($sformatf("r%0d_active", n), int'(bus.active_bank), int'(m_active));
    chk($sformatf("r%0d_ack", n), int'(bus.remap_ack), int'(e_ack));
    chk($sformatf("r%0d_done", n), int'(bus.load_done), int'(e_done));
    chk($sformatf("r%0d_err", n), int'(bus.load_err), int'(e_err));
    chk($sformatf("r%0d_busy", n), int'(bus.load_busy), int'(m_loading));
    chk($sformatf("r%0d_ready", n), int'(bus.load_ready), int'(m_loading));
    chk($sformatf("r%0d_count", n), int'(bus.load_count), m_count);
    chk($sformatf("r%0d_sum", n), int'(bus.load_sum), int'(m_sum));
    if (e_known) chk($sformatf("r%0d_inst", n), int'(bus.inst_data_out), int'(e_inst));
  endtask

  task automatic exp5(input string t, input int act, input int ack, input int done,
                      input int busy, input int cnt);
    chk({t, "_active"}, int'(bus.active_bank), act);
    chk({t, "_ack"}, int'(bus.remap_ack), ack);
    chk({t, "_done"}, int'(bus.load_done), done);
    chk({t, "_busy"}, int'(bus.load_busy), busy);
    chk({t, "_count"}, int'(bus.load_count), cnt);
  endtask

  localparam int NT = 18;
  vec_t tbl [NT];

  initial begin
    in_t idle;
    in_t r;
    idle = '0;

    tbl[0]  = mkv(mkin(0,     0,0, 1,1,'h3FE, 0,0,0), 0,0,0,0,1,0,0,  1, rom_fn(0));
    tbl[1]  = mkv(mkin(0,     0,0, 0,0,0,     1,1,0), 0,0,0,0,1,1,1,  1, rom_fn(0));
    tbl[2]  = mkv(mkin(0,     0,0, 0,0,0,     1,2,0), 0,0,0,0,1,2,3,  1, rom_fn(0));
    tbl[3]  = mkv(mkin(0,     0,0, 0,0,0,     1,3,0), 0,0,0,0,1,3,6,  1, rom_fn(0));
    tbl[4]  = mkv(mkin(0,     0,0, 0,0,0,     1,4,1), 0,0,1,0,0,4,10, 1, rom_fn(0));
    tbl[5]  = mkv(mkin(0,     0,0, 0,0,0,     0,0,0), 0,0,0,0,0,4,10, 1, rom_fn(0));
    tbl[6]  = mkv(mkin('h3FF, 1,1, 0,0,0,     0,0,0), 1,1,0,0,0,4,10, 1, rom_fn(10'h3FF));
    tbl[7]  = mkv(mkin('h3FF, 0,0, 0,0,0,     0,0,0), 1,0,0,0,0,4,10, 1, 18'h2);
    tbl[8]  = mkv(mkin(0,     0,0, 0,0,0,     0,0,0), 1,0,0,0,0,4,10, 1, 18'h3);
    tbl[9]  = mkv(mkin(1,     0,0, 0,0,0,     0,0,0), 1,0,0,0,0,4,10, 1, 18'h4);
    tbl[10] = mkv(mkin('h3FE, 0,0, 0,0,0,     0,0,0), 1,0,0,0,0,4,10, 1, 18'h1);
    tbl[11] = mkv(mkin(0,     0,0, 1,1,0,     0,0,0), 1,0,0,1,0,4,10, 1, 18'h3);
    tbl[12] = mkv(mkin(0,     1,7, 0,0,0,     0,0,0), 1,0,0,1,0,4,10, 1, 18'h3);
    tbl[13] = mkv(mkin(0,     1,1, 0,0,0,     0,0,0), 1,1,0,0,0,4,10, 1, 18'h3);
    tbl[14] = mkv(mkin(0,     0,0, 1,3,0,     0,0,0), 1,0,0,1,0,4,10, 1, 18'h3);
    tbl[15] = mkv(mkin(0,     1,2, 1,2,0,     0,0,0), 2,1,0,1,0,4,10, 1, 18'h3);
    tbl[16] = mkv(mkin(0,     1,0, 0,0,0,     0,0,0), 0,1,0,0,0,4,10, 0, 18'h0);
    tbl[17] = mkv(mkin(5,     0,0, 0,0,0,     0,0,0), 0,0,0,0,0,4,10, 1, rom_fn(10'h5));

    // Reset state
    drive(idle);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    exp5("rst", RESET_BANK, 0, 0, 0, 0);
    chk("rst_err", int'(bus.load_err), 0);
    chk("rst_sum", int'(bus.load_sum), 0);
    chk("rst_inst", int'(bus.inst_data_out), 0);
    chk("rst_ready", int'(bus.load_ready), 0);

    // Directed table: wrap-around upload, fetch from RAM, rejects, same-bank remap
    for (int k = 0; k < NT; k++) begin
      drive(tbl[k].i);
      step();
      chk($sformatf("t%0d_romaddr", k), int'(bus.rom_address), int'(tbl[k].i.inst_address));
      chk($sformatf("t%0d_active", k), int'(bus.active_bank), int'(tbl[k].act));
      chk($sformatf("t%0d_ack", k), int'(bus.remap_ack), int'(tbl[k].ack));
      chk($sformatf("t%0d_done", k), int'(bus.load_done), int'(tbl[k].done));
      chk($sformatf("t%0d_err", k), int'(bus.load_err), int'(tbl[k].err));
      chk($sformatf("t%0d_busy", k), int'(bus.load_busy), int'(tbl[k].busy));
      chk($sformatf("t%0d_count", k), int'(bus.load_count), tbl[k].cnt);
      chk($sformatf("t%0d_sum", k), int'(bus.load_sum), tbl[k].sum);
      if (tbl[k].ci) chk($sformatf("t%0d_inst", k), int'(bus.inst_data_out), int'(tbl[k].inst));
    end

    // Remap to the bank under upload is deferred to the load_done cycle
    drive(mkin(0, 0,0, 1,2,'h100, 0,0,0));    step(); exp5("p0", 0, 0, 0, 1, 0);
    drive(mkin(0, 1,2, 0,0,0, 1,'h11,0));     step(); exp5("p1", 0, 0, 0, 1, 1);
    drive(mkin(0, 0,0, 0,0,0, 1,'h22,0));     step(); exp5("p2", 0, 0, 0, 1, 2);
    drive(mkin(0, 0,0, 0,0,0, 1,'h33,1));     step(); exp5("p3", 2, 1, 1, 0, 3);
    chk("p3_sum", int'(bus.load_sum), 'h66);
    drive(idle);                              step(); exp5("p4", 2, 0, 0, 0, 3);

    // Reset in the middle of an upload
    drive(mkin(0, 0,0, 1,1,'h20, 0,0,0));     step();
    drive(mkin(0, 0,0, 0,0,0, 1,5,0));        step();
    drive(mkin(0, 0,0, 0,0,0, 1,6,0));        step(); exp5("q0", 2, 0, 0, 1, 2);
    drive(mkin(0, 0,0, 0,0,0, 1,7,0));
    #2 rst_n = 1'b0;
    #1;
    exp5("q1", RESET_BANK, 0, 0, 0, 0);
    chk("q1_sum", int'(bus.load_sum), 0);
    chk("q1_inst", int'(bus.inst_data_out), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("q2_%0d_done", k), int'(bus.load_done), 0);
      chk($sformatf("q2_%0d_busy", k), int'(bus.load_busy), 0);
    end
    drive(idle);
    rst_n = 1'b1;
    model_reset();
    step(); exp5("q3", RESET_BANK, 0, 0, 0, 0);

    // Upload with no load_last ends when the bank is full
    drive(mkin(0, 0,0, 1,1,'h155, 0,0,0));    step(); exp5("f0", 0, 0, 0, 1, 0);
    for (int k = 0; k < DEPTH; k++) begin
      drive(mkin(0, 0,0, 0,0,0, 1,k,0));
      step();
      if (k == DEPTH - 2) exp5("f1", 0, 0, 0, 1, DEPTH - 1);
      if (k == DEPTH - 1) begin
        exp5("f2", 0, 0, 1, 0, DEPTH);
        chk("f2_sum", int'(bus.load_sum), ((DEPTH - 1) * DEPTH / 2) % (1 << DW));
      end
    end
    drive(idle); step(); exp5("f3", 0, 0, 0, 0, DEPTH);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = '0;
      r.inst_address = AW'($urandom_range(0, 47));
      r.remap_req    = ($urandom_range(0, 11) == 0);
      r.remap_bank   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(0, NBANK));
      r.load_start   = ($urandom_range(0, 7) == 0);
      r.load_bank    = 3'($urandom_range(0, 3));
      r.load_base    = AW'($urandom_range(0, 40));
      r.load_valid   = 1'($urandom_range(0, 1));
      r.load_data    = DW'($urandom);
      r.load_last    = ($urandom_range(0, 7) == 0);
      drive(r);
      step();
      cmp_model(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/picocode_bank_ctrl.md
PICOCODE_BANK_CTRL -- requirements
Module: picocode_bank_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10, meaning instruction address width (bank depth 2^AW words).
REQ-002 SHALL have parameter DW, default 18, meaning instruction word width.
REQ-003 SHALL have parameter NBANK, default 2, meaning number of internal RAM banks (1..7); BW = 3 is the bank-index width.
REQ-004 SHALL have parameter RESET_BANK, default 0, meaning active bank after reset (0 = external ROM, 1..NBANK = RAM).
REQ-005 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  in  1  system clock, all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 inst_address  in  AW  CPU fetch address.
REQ-009 inst_data_out  out  DW  fetched instruction, 1-cycle latency.
REQ-010 rom_address  out  AW  address to external synchronous ROM (1-cycle read latency).
REQ-011 rom_data  in  DW  ROM read data.
REQ-012 active_bank  out  BW  bank currently serving fetches.
REQ-013 remap_req  in  1  single-cycle request to switch active bank.
REQ-014 remap_bank  in  BW  target bank for remap_req.
REQ-015 remap_ack  out  1  one-cycle pulse when a remap is applied.
REQ-016 load_start  in  1  single-cycle request to begin upload.
REQ-017 load_bank  in  BW  target RAM bank for upload.
REQ-018 load_base  in  AW  first write address of upload.
REQ-019 load_valid / load_ready  in / out  1  upload beat handshake.
REQ-020 load_data  in  DW  upload word.
REQ-021 load_last  in  1  marks final beat.
REQ-022 load_busy  out  1  high in LOAD state.
REQ-023 load_done  out  1  one-cycle pulse when upload completes.
REQ-024 load_err  out  1  one-cycle pulse on rejected request.
REQ-025 load_count  out  AW+1  beats accepted in current/last upload.
REQ-026 load_sum  out  DW  modulo-2^DW sum of accepted words.

Function
REQ-027 rom_address SHALL equal inst_address combinationally at all times.
REQ-028 inst_data_out SHALL be, one cycle after inst_address presented, the word from the bank that was active in the presentation cycle (ROM via rom_data, RAM via registered read).
REQ-029 State machine SHALL have states IDLE and LOAD; load_ready = load_busy = (state == LOAD).
REQ-030 In IDLE, load_start with 1 <= load_bank <= NBANK and load_bank != active_bank and no pending remap to load_bank SHALL enter LOAD next cycle, latching bank and load_base, clearing load_count and load_sum.
REQ-031 Any other load_start (invalid bank, bank active or pending-active, or state LOAD) SHALL be ignored and pulse load_err next cycle.
REQ-032 Each accepted beat (load_valid & load_ready) SHALL write load_data at current address, increment address modulo 2^AW, increment load_count, add load_data to load_sum modulo 2^DW.
REQ-033 Beat with load_last, or beat making load_count = 2^AW, SHALL return to IDLE next cycle and pulse load_done in that cycle; load_count and load_sum hold until next accepted load_start.
REQ-034 remap_req with remap_bank > NBANK SHALL be ignored and pulse load_err.
REQ-035 Valid remap_req SHALL update active_bank and pulse remap_ack in the next cycle, unless remap_bank equals the bank being loaded.
REQ-036 Remap to the bank being loaded SHALL be held pending (one entry; a newer remap_req replaces it) and applied, with remap_ack, in the cycle load_done pulses.
REQ-037 remap_req to current active_bank SHALL still pulse remap_ack with no change.
REQ-038 Simultaneous load_start and remap_req in IDLE to the same bank: remap wins, load_start rejected with load_err.

Reset
REQ-039 On rst_n low: state IDLE, active_bank = RESET_BANK, pending cleared, inst_data_out, remap_ack, load_done, load_err, load_count, load_sum all 0; an in-progress upload aborts with no load_done.
REQ-040 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-041 Upload 4 words 0x00001..0x00004 to bank 1 at base 0x3FE, last on beat 4 -> addresses 0x3FE,0x3FF,0x000,0x001 written, load_count = 4, load_sum = 0x0000A, one load_done pulse.
REQ-042 After REQ-041, remap_req bank 1, fetch 0x3FF -> remap_ack next cycle, inst_data_out = 0x00002 one cycle after address.
REQ-043 With active_bank = 1, load_start bank 1 -> load_err pulse, state stays IDLE, bank 1 unchanged.
REQ-044 During upload to bank 2, remap_req bank 2 -> active_bank unchanged until load_done cycle, then 2 with remap_ack same cycle.
REQ-045 Deassert rst_n mid-upload -> load_busy 0, load_count 0, no load_done, active_bank = RESET_BANK.
REQ-046 remap_req bank 7 with NBANK = 2 -> load_err pulse, active_bank unchanged, no remap_ack.
